// File: rtl/y_md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package y_md_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/y_add_sub.sv
// WIDTH+1 bit adder/subtractor; sub inverts b and injects the carry-in.
module y_add_sub
    import y_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] s,
    output logic           cout
);

    logic [WIDTH:0] b_eff;

    assign b_eff     = sub ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/y_mul_div.sv
// Iterative RV32M multiply/divide: one bit per cycle over WIDTH cycles, then a
// single fix-up cycle that applies sign and RISC-V special-case results.
module y_mul_div
    import y_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    md_state_e          state, state_nxt;
    md_op_e             op_r;
    logic               rsign, div_zero, ovf;
    logic [WIDTH-1:0]   a_orig, opd, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               sa, sb, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_a, add_b, add_s;
    logic               add_sub, add_cout;
    logic [WIDTH-1:0]   fix_opd, neg_val, res;
    logic [WIDTH-1:0]   new_rem;

    assign sa     = sgn & a[WIDTH-1];
    assign sb     = sgn & b[WIDTH-1];
    assign a_mag  = mag(a, sgn);
    assign b_mag  = mag(b, sgn);
    assign is_div = op_r[1];

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            MD_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = MD_RUN;
            end
            MD_RUN:  if (cnt == CNT_LAST) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One shared adder: multiply add, divide trial-subtract, or FIX negation (0 - x).
    always_comb begin
        add_a   = '0;
        add_b   = {1'b0, fix_opd};
        add_sub = 1'b1;
        if (state == MD_RUN) begin
            if (is_div) begin
                add_a = acc[2*WIDTH-1:WIDTH-1];
                add_b = {1'b0, opd};
            end else begin
                add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
                add_b   = mplier[0] ? {1'b0, opd} : '0;
                add_sub = 1'b0;
            end
        end
    end

    y_add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .s    (add_s),
        .cout (add_cout)
    );

    assign new_rem = add_cout ? add_s[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1];

    // Negating the high half of a 2*WIDTH product only needs the +1 when the low half is zero.
    always_comb begin
        fix_opd = acc[WIDTH-1:0];
        if (op_r == MD_MULH || op_r == MD_REM) fix_opd = acc[2*WIDTH-1:WIDTH];
        neg_val = add_s[WIDTH-1:0];
        if (op_r == MD_MULH && (|acc[WIDTH-1:0])) neg_val = ~acc[2*WIDTH-1:WIDTH];
        res = rsign ? neg_val : fix_opd;
        if (op_r == MD_DIV) begin
            if (div_zero)  res = '1;
            else if (ovf)  res = a_orig;
        end else if (op_r == MD_REM) begin
            if (div_zero)  res = a_orig;
            else if (ovf)  res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            cnt  <= '0;
            z    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: if (start) begin
                    acc <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                    cnt <= '0;
                end
                MD_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) acc <= {new_rem, acc[WIDTH-2:0], add_cout};
                    else        acc <= {add_s, acc[WIDTH-1:1]};
                end
                MD_FIX: begin
                    z    <= res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand registers only matter between acceptance and FIX, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == MD_IDLE && start) begin
            op_r     <= md_op_e'(op);
            rsign    <= (op == MD_REM) ? sa : (sa ^ sb);
            div_zero <= (b == '0);
            ovf      <= sgn && (a == MOST_NEG) && (b == '1);
            a_orig   <= a;
            opd      <= op[1] ? b_mag : a_mag;
            mplier   <= b_mag;
        end else if (state == MD_RUN) begin
            mplier <= mplier >> 1;
        end
    end

endmodule
